// File: rtl/vgachargen_pkg.sv
// Shared types and address-map constants for the VGA character generator APB bridge.
package vgachargen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RGN_CH_MAP  = 2'd0,
    RGN_COL_MAP = 2'd1,
    RGN_CH_T    = 2'd2,
    RGN_NONE    = 2'd3
  } region_t;

  localparam int unsigned CH_MAP_WORDS_DEF  = 600;
  localparam int unsigned COL_MAP_WORDS_DEF = 600;
  localparam int unsigned CH_T_WORDS_DEF    = 1024;

  localparam logic [13:0] CH_MAP_BASE  = 14'h0000;
  localparam logic [13:0] COL_MAP_BASE = 14'h1000;
  localparam logic [13:0] CH_T_BASE    = 14'h2000;

  localparam logic [13:0] CH_MAP_LIMIT  = 14'h095F;
  localparam logic [13:0] COL_MAP_LIMIT = 14'h195F;
  localparam logic [13:0] CH_T_LIMIT    = 14'h2FFF;

  localparam logic [1:0] CH_MAP_PAGE  = CH_MAP_BASE[13:12];
  localparam logic [1:0] COL_MAP_PAGE = COL_MAP_BASE[13:12];
  localparam logic [1:0] CH_T_PAGE    = CH_T_BASE[13:12];

  // Each region occupies one 4 KiB page; lim is the region size in bytes.
  function automatic region_t decode_region(input logic [13:0] off,
                                            input logic [12:0] ch_lim,
                                            input logic [12:0] col_lim,
                                            input logic [12:0] cht_lim);
    region_t     r;
    logic [12:0] ofs;
    ofs = {1'b0, off[11:0]};
    r   = RGN_NONE;
    if (off[1:0] == 2'b00) begin
      case (off[13:12])
        CH_MAP_PAGE:  r = (ofs < ch_lim)  ? RGN_CH_MAP  : RGN_NONE;
        COL_MAP_PAGE: r = (ofs < col_lim) ? RGN_COL_MAP : RGN_NONE;
        CH_T_PAGE:    r = (ofs < cht_lim) ? RGN_CH_T    : RGN_NONE;
        default:      r = RGN_NONE;
      endcase
    end else begin
      r = RGN_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/vgachargen_apb_bridge.sv
// APB slave bridging onto the char-map, colour-map and glyph-table memory ports.
module vgachargen_apb_bridge
  import vgachargen_pkg::*;
#(
  parameter int unsigned CH_MAP_WORDS  = CH_MAP_WORDS_DEF,
  parameter int unsigned COL_MAP_WORDS = COL_MAP_WORDS_DEF,
  parameter int unsigned CH_T_WORDS    = CH_T_WORDS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [9:0]  ch_map_addr_o,
  output logic [31:0] ch_map_data_o,
  output logic [3:0]  ch_map_wen_o,
  input  logic [31:0] ch_map_data_i,
  output logic [9:0]  col_map_addr_o,
  output logic [31:0] col_map_data_o,
  output logic [3:0]  col_map_wen_o,
  input  logic [31:0] col_map_data_i,
  output logic [9:0]  ch_t_addr_o,
  output logic [31:0] ch_t_data_o,
  output logic [3:0]  ch_t_wen_o,
  input  logic [31:0] ch_t_data_i
);

  localparam logic [12:0] CH_MAP_LIM  = 13'(CH_MAP_WORDS * 4);
  localparam logic [12:0] COL_MAP_LIM = 13'(COL_MAP_WORDS * 4);
  localparam logic [12:0] CH_T_LIM    = 13'(CH_T_WORDS * 4);

  state_t      state_r;
  state_t      state_nxt_s;
  region_t     rgn_s;
  region_t     sel_r;
  logic [9:0]  word_idx_s;
  logic        wr_go_s;
  logic        rd_go_s;
  logic        err_go_s;
  logic        cap_s;
  logic        unused_addr_bits;

  assign rgn_s            = decode_region(paddr_i[13:0], CH_MAP_LIM, COL_MAP_LIM, CH_T_LIM);
  assign word_idx_s       = paddr_i[11:2];
  assign unused_addr_bits = ^paddr_i[31:14];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and single-cycle action strobes; RD_WAIT/DONE ignore psel so a dropped psel cannot abort.
  always_comb begin
    state_nxt_s = state_r;
    wr_go_s     = 1'b0;
    rd_go_s     = 1'b0;
    err_go_s    = 1'b0;
    cap_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (psel_i && penable_i) begin
          if (rgn_s == RGN_NONE) begin
            err_go_s    = 1'b1;
            state_nxt_s = ST_DONE;
          end else if (pwrite_i) begin
            wr_go_s     = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            rd_go_s     = 1'b1;
            state_nxt_s = ST_RD_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        cap_s       = 1'b1;
        state_nxt_s = ST_DONE;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered APB response and memory-port drive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pready_o       <= 1'b0;
      pslverr_o      <= 1'b0;
      prdata_o       <= 32'h0;
      sel_r          <= RGN_NONE;
      ch_map_addr_o  <= 10'h0;
      ch_map_data_o  <= 32'h0;
      ch_map_wen_o   <= 4'h0;
      col_map_addr_o <= 10'h0;
      col_map_data_o <= 32'h0;
      col_map_wen_o  <= 4'h0;
      ch_t_addr_o    <= 10'h0;
      ch_t_data_o    <= 32'h0;
      ch_t_wen_o     <= 4'h0;
    end else begin
      pready_o      <= (state_nxt_s == ST_DONE);
      pslverr_o     <= err_go_s;
      ch_map_wen_o  <= (wr_go_s && (rgn_s == RGN_CH_MAP))  ? pstrb_i : 4'h0;
      col_map_wen_o <= (wr_go_s && (rgn_s == RGN_COL_MAP)) ? pstrb_i : 4'h0;
      ch_t_wen_o    <= (wr_go_s && (rgn_s == RGN_CH_T))    ? pstrb_i : 4'h0;

      if (wr_go_s || rd_go_s) begin
        sel_r <= rgn_s;
        case (rgn_s)
          RGN_CH_MAP: begin
            ch_map_addr_o <= word_idx_s;
            if (wr_go_s) ch_map_data_o <= pwdata_i;
          end
          RGN_COL_MAP: begin
            col_map_addr_o <= word_idx_s;
            if (wr_go_s) col_map_data_o <= pwdata_i;
          end
          RGN_CH_T: begin
            ch_t_addr_o <= word_idx_s;
            if (wr_go_s) ch_t_data_o <= pwdata_i;
          end
          default: begin
          end
        endcase
      end

      if (err_go_s) begin
        prdata_o <= 32'h0;
      end else if (cap_s) begin
        case (sel_r)
          RGN_CH_MAP:  prdata_o <= ch_map_data_i;
          RGN_COL_MAP: prdata_o <= col_map_data_i;
          RGN_CH_T:    prdata_o <= ch_t_data_i;
          default:     prdata_o <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vgachargen_apb_bridge.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs. a transaction model.
module tb_vgachargen_apb_bridge;

  logic        clk = 1'b0;
  logic        rst, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [9:0]  ch_map_addr, col_map_addr, ch_t_addr;
  logic [31:0] ch_map_wdata, col_map_wdata, ch_t_wdata;
  logic [31:0] ch_map_rdata, col_map_rdata, ch_t_rdata;
  logic [3:0]  ch_map_wen, col_map_wen, ch_t_wen;

  always #5 clk = ~clk;

  vgachargen_apb_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .ch_map_addr_o(ch_map_addr), .ch_map_data_o(ch_map_wdata),
    .ch_map_wen_o(ch_map_wen), .ch_map_data_i(ch_map_rdata),
    .col_map_addr_o(col_map_addr), .col_map_data_o(col_map_wdata),
    .col_map_wen_o(col_map_wen), .col_map_data_i(col_map_rdata),
    .ch_t_addr_o(ch_t_addr), .ch_t_data_o(ch_t_wdata),
    .ch_t_wen_o(ch_t_wen), .ch_t_data_i(ch_t_rdata)
  );

  // Memories attached to the bridge: registered address, so data follows one cycle after the decode.
  logic        tb_init;
  logic [31:0] mem_ch  [0:1023];
  logic [31:0] mem_col [0:1023];
  logic [31:0] mem_cht [0:1023];
  assign ch_map_rdata  = mem_ch[ch_map_addr];
  assign col_map_rdata = mem_col[col_map_addr];
  assign ch_t_rdata    = mem_cht[ch_t_addr];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem_ch[i] <= 32'h0; mem_col[i] <= 32'h0; mem_cht[i] <= 32'h0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ch_map_wen[b])  mem_ch[ch_map_addr][b*8 +: 8]   <= ch_map_wdata[b*8 +: 8];
        if (col_map_wen[b]) mem_col[col_map_addr][b*8 +: 8] <= col_map_wdata[b*8 +: 8];
        if (ch_t_wen[b])    mem_cht[ch_t_addr][b*8 +: 8]    <= ch_t_wdata[b*8 +: 8];
      end
    end
  end

  // Protocol monitors sampled on the falling edge.
  int         pready_cnt, wen_cyc, excl_bad, err_bad, last_rgn;
  logic [3:0] last_wen;
  always @(negedge clk) begin
    if (tb_init) begin
      pready_cnt <= 0; wen_cyc <= 0; excl_bad <= 0; err_bad <= 0;
      last_wen <= 4'h0; last_rgn <= -1;
    end else begin
      if (pready) pready_cnt <= pready_cnt + 1;
      if (pslverr && !pready) err_bad <= err_bad + 1;
      if ((int'(ch_map_wen != 4'h0) + int'(col_map_wen != 4'h0) + int'(ch_t_wen != 4'h0)) > 1)
        excl_bad <= excl_bad + 1;
      if (ch_map_wen != 4'h0) begin
        wen_cyc <= wen_cyc + 1; last_wen <= ch_map_wen; last_rgn <= 0;
      end else if (col_map_wen != 4'h0) begin
        wen_cyc <= wen_cyc + 1; last_wen <= col_map_wen; last_rgn <= 1;
      end else if (ch_t_wen != 4'h0) begin
        wen_cyc <= wen_cyc + 1; last_wen <= ch_t_wen; last_rgn <= 2;
      end
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] shadow [0:2][0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference address map, straight from the byte ranges.
  function automatic void ref_decode(input logic [31:0] a, output int rgn, output int idx);
    int b;
    b = int'(a & 32'h0000_3FFF);
    rgn = -1;
    idx = 0;
    if (b % 4 != 0) rgn = -1;
    else if (b < 2400) begin rgn = 0; idx = b / 4; end
    else if (b >= 4096 && b < 4096 + 2400) begin rgn = 1; idx = (b - 4096) / 4; end
    else if (b >= 8192 && b < 12288) begin rgn = 2; idx = (b - 8192) / 4; end
  endfunction

  function automatic logic [9:0] dut_addr(input int r);
    if (r == 0) return ch_map_addr;
    else if (r == 1) return col_map_addr;
    else return ch_t_addr;
  endfunction

  // One APB transfer; cyc is the access-phase cycle on which pready was seen (0 = timeout).
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic hold,
                     output logic [31:0] rd, output logic err, output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0; rd = 32'h0; err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pready) begin
        cyc = k; rd = prdata; err = pslverr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    penable = 1'b0;
    psel = hold;
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input logic hold,
                         input logic exp_err, input int exp_cyc, input logic [31:0] exp_rd,
                         input logic [3:0] exp_wen, input int exp_rgn, input int exp_idx);
    int          p0, w0, rgn, idx, cyc;
    logic [31:0] rd;
    logic        err;
    p0 = pready_cnt;
    w0 = wen_cyc;
    apb(wr, a, wd, st, hold, rd, err, cyc);
    check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " pslverr"}, 32'(err), 32'(exp_err));
    check({tag, " pready_pulses"}, 32'(pready_cnt - p0), 32'd1);
    if (!wr) check({tag, " prdata"}, rd, exp_rd);
    check({tag, " wen_cycles"}, 32'(wen_cyc - w0), (exp_wen != 4'h0) ? 32'd1 : 32'd0);
    if (exp_wen != 4'h0) begin
      check({tag, " wen_value"}, 32'(last_wen), 32'(exp_wen));
      check({tag, " wen_region"}, 32'(last_rgn), 32'(exp_rgn));
    end
    if (exp_rgn >= 0) check({tag, " mem_addr"}, 32'(dut_addr(exp_rgn)), 32'(exp_idx));
    ref_decode(a, rgn, idx);
    if (wr && rgn >= 0)
      for (int b = 0; b < 4; b++)
        if (st[b]) shadow[rgn][idx][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wen;
    int          exp_rgn;
    int          exp_idx;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int          rgn, idx, k;
    logic        wr, hold;
    logic [31:0] a, wd;
    logic [3:0]  st;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h4142_4344, 4'hF, 1'b0, 2, 32'h0,          4'hF, 0,  1};
    vecs[1]  = '{1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF, 1'b0, 2, 32'h0,          4'hF, 2,  4};
    vecs[2]  = '{1'b0, 32'h0000_2010, 32'h0,         4'h0, 1'b0, 3, 32'hDEAD_BEEF,  4'h0, 2,  4};
    vecs[3]  = '{1'b1, 32'h0000_0960, 32'h1234_5678, 4'hF, 1'b1, 2, 32'h0,          4'h0, -1, 0};
    vecs[4]  = '{1'b0, 32'h0000_1002, 32'h0,         4'h0, 1'b1, 2, 32'h0,          4'h0, -1, 0};
    vecs[5]  = '{1'b1, 32'h0000_195C, 32'h1122_3344, 4'hF, 1'b0, 2, 32'h0,          4'hF, 1,  599};
    vecs[6]  = '{1'b1, 32'h0000_195C, 32'hAABB_CCDD, 4'h5, 1'b0, 2, 32'h0,          4'h5, 1,  599};
    vecs[7]  = '{1'b1, 32'h0000_195C, 32'hFFFF_FFFF, 4'h0, 1'b0, 2, 32'h0,          4'h0, 1,  599};
    vecs[8]  = '{1'b0, 32'h0000_195C, 32'h0,         4'h0, 1'b0, 3, 32'h11BB_33DD,  4'h0, 1,  599};
    vecs[9]  = '{1'b0, 32'hFFFF_0004, 32'h0,         4'h0, 1'b0, 3, 32'h4142_4344,  4'h0, 0,  1};
    vecs[10] = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 1'b1, 2, 32'h0,          4'h0, -1, 0};
    vecs[11] = '{1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 4'h3, 1'b0, 2, 32'h0,          4'h3, 2,  1023};
    vecs[12] = '{1'b0, 32'h0000_2FFC, 32'h0,         4'h0, 1'b0, 3, 32'h0000_F00D,  4'h0, 2,  1023};
    vecs[13] = '{1'b0, 32'h0000_095C, 32'h0,         4'h0, 1'b0, 3, 32'h0,          4'h0, 0,  599};
    vecs[14] = '{1'b0, 32'h0000_1960, 32'h0,         4'h0, 1'b1, 2, 32'h0,          4'h0, -1, 0};
    vecs[15] = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 1'b1, 2, 32'h0,          4'h0, -1, 0};

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 1024; i++) shadow[r][i] = 32'h0;

    rst = 1'b1; tb_init = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 tb_init = 1'b0;
    @(negedge clk);
    check("reset pready", 32'(pready), 32'd0);
    check("reset pslverr", 32'(pslverr), 32'd0);
    check("reset prdata", prdata, 32'h0);
    check("reset wen", 32'({ch_map_wen, col_map_wen, ch_t_wen}), 32'h0);
    check("reset addr", 32'({ch_map_addr, col_map_addr, ch_t_addr}), 32'h0);
    check("reset data", ch_map_wdata | col_map_wdata | ch_t_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
              1'b0, vecs[i].exp_err, vecs[i].exp_cyc, vecs[i].exp_rdata, vecs[i].exp_wen,
              vecs[i].exp_rgn, vecs[i].exp_idx);

    // Reset while the read is waiting on memory: no response, outputs cleared.
    k = pready_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_2010;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rdwait_rst pready", 32'(pready), 32'd0);
    check("rdwait_rst prdata", prdata, 32'h0);
    check("rdwait_rst addr", 32'({ch_map_addr, col_map_addr, ch_t_addr}), 32'h0);
    repeat (3) @(negedge clk);
    check("rdwait_rst no_pulse", 32'(pready_cnt - k), 32'd0);
    @(posedge clk); #1;
    run_txn("after_rst", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, 1'b0, 3, 32'h4142_4344, 4'h0, 0, 1);

    // Setup phase alone must not touch memory.
    k = pready_cnt; idx = wen_cyc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0008; pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1 psel = 1'b0;
    @(negedge clk);
    check("setup_only wen", 32'(wen_cyc - idx), 32'd0);
    check("setup_only pready", 32'(pready_cnt - k), 32'd0);
    check("setup_only addr", 32'(ch_map_addr), 32'd1);
    @(posedge clk); #1;

    // psel dropped after the first access cycle: the read still completes.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_2010;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    k = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (pready) begin k = c; check("psel_drop prdata", prdata, 32'hDEAD_BEEF); break; end
    end
    check("psel_drop ready_cycle", 32'(k), 32'd2);
    @(posedge clk); #1;

    // Back-to-back transfers with psel held high.
    run_txn("b2b_wr", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 2, 32'h0, 4'hF, 0, 4);
    run_txn("b2b_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 3, 32'hCAFE_F00D, 4'h0, 0, 4);
    run_txn("b2b_rd2", 1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 1'b0, 1'b0, 3, 32'h0000_F00D, 4'h0, 2, 1023);

    // Random traffic against the transaction model.
    for (int n = 0; n < 150; n++) begin
      a = {$urandom_range(0, 262143), 14'h0};
      a[13:12] = 2'($urandom_range(0, 3));
      a[11:2]  = 10'($urandom_range(0, 1023));
      a[1:0]   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      hold = 1'($urandom_range(0, 1));
      ref_decode(a, rgn, idx);
      run_txn($sformatf("rnd%0d", n), wr, a, wd, st, hold, (rgn < 0),
              (rgn < 0) ? 2 : (wr ? 2 : 3),
              (rgn < 0) ? 32'h0 : shadow[rgn][idx],
              (wr && rgn >= 0) ? st : 4'h0, rgn, idx);
    end
    psel = 1'b0;
    @(posedge clk); #1;

    check("wen_exclusive", 32'(excl_bad), 32'd0);
    check("pslverr_only_with_pready", 32'(err_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
